clkdiv_cfg_sched: RTL and testbench
===================================

// Module: clkdiv_cfg_sched
// PURPOSE
//  Shares one integer clock divider among NREQ requesters that each want to set its ratio.
//  Round-robin arbitrates ratio-change requests and sequences each change safely:
//  wait for the divided clock to be low, gate the divider, load the ratio, re-enable.
//  Sits between software/config agents and the divider's enable/ratio inputs.
// PARAMETERS
//  WIDTH        8    divider ratio width
//  NREQ         4    number of requesters (>=2)
//  STALL        2    cycles div_enable is held low around a ratio load (>=1)
//  RESET_RATIO  2    div_ratio value after reset (must be >=2)
//  TIMEOUT      255  DRAIN wait limit in clk cycles (used only with CLKDIV_CFG_TIMEOUT_EN)
// PORTS
//  clk          in   1           system clock
//  reset_n      in   1           reset
//  run          in   1           global run; div_enable = run & internal enable
//  req          in   NREQ        per-requester change request, level, held until ack
//  req_ratio    in   NREQ*WIDTH  requested ratio, slice i = req_ratio[i*WIDTH +: WIDTH]
//  div_clk_fb   in   1           divided clock fed back from the divider (same clk domain)
//  div_enable   out  1           divider enable
//  div_ratio    out  WIDTH       divider ratio, registered
//  ack          out  NREQ        one-cycle one-hot completion pulse
//  err          out  1           one-cycle pulse with ack when the request was rejected
//  busy         out  1           high in any state other than IDLE
// BEHAVIOUR
//  Reset (reset_n low, asynchronous): state=IDLE, div_ratio=RESET_RATIO, internal enable=1,
//   ack=0, err=0, busy=0, rr pointer=0; div_enable=run.
//  FSM: IDLE -> DRAIN -> GATE -> LOAD -> RESUME -> IDLE.
//  IDLE: if any req, grant the first set bit at or after rr pointer (wrapping); latch index and ratio.
//   rr pointer <= winner+1 mod NREQ.
//   Ratio 0 or 1: ack[winner]=1 and err=1 next cycle; stay IDLE.
//   Ratio equal to div_ratio: ack next cycle, err=0, no gating; stay IDLE.
//   Otherwise -> DRAIN.
//  DRAIN: wait for div_clk_fb==0; on that cycle -> GATE. Enable is unchanged while waiting.
//   With run=0, div_clk_fb is static: wait indefinitely unless timeout is compiled in.
//  GATE: internal enable=0 for STALL cycles (counter), then -> LOAD.
//  LOAD: div_ratio <= latched ratio (1 cycle, enable still 0) -> RESUME.
//  RESUME: internal enable=1; ack[winner]=1 for 1 cycle; -> IDLE.
//   A new grant may be taken on the next IDLE cycle.
//  Latency for a valid change with div_clk_fb already low: req sampled at cycle 0, ack at cycle 3+STALL.
//  Latched ratio/index are frozen after grant; req dropping or req_ratio changing mid-sequence
//   does not abort; ack is still issued.
//  Requests are not sampled while busy; a req held high at ack is re-arbitrated as a new request.
//  Asynchronous reset mid-sequence returns everything to the reset values; no ack is issued.
//  ack and err are never asserted outside the cycles defined above; ack is always one-hot or zero.
// CONFIGURATION
//  CLKDIV_CFG_TIMEOUT_EN defined:
//   - Adds output port timeout (1 bit).
//   - DRAIN counts cycles; at TIMEOUT cycles without div_clk_fb==0, pulse timeout for 1 cycle.
//   - Proceed to GATE anyway; the change completes normally with ack, err=0.
//  Not defined: no port, no counter; DRAIN waits indefinitely.
// STRUCTURE
//  Shared package clkdiv_pkg: FSM state encoding (IDLE..RESUME),
//   ratio-validity function (ratio>=2), shared with the divider.
//  Sub-module clkdiv_rr_arb: NREQ-way round-robin arbiter.
//   Inputs: req, pointer. Outputs: one-hot grant, encoded index. Purely combinational.
//  This module holds the FSM, the STALL/TIMEOUT counter, and the ratio/index latches.
// TESTING
//  1 Reset, run=1, no req -> div_ratio=2, div_enable=1, busy=0, ack=0.
//  2 req[1] ratio 5, div_clk_fb low -> enable low STALL=2 cycles; div_ratio=5 in LOAD;
//    ack[1] at cycle 5; enable=1.
//  3 req[0]=req[2]=req[3] together, pointer=1 -> grants in order 2, 3, 0; exactly one ack per grant.
//  4 req[2] ratio 1 -> ack[2] and err together next cycle; div_enable never drops; div_ratio unchanged.
//  5 req[0] ratio 4, div_clk_fb high 10 cycles -> stays DRAIN, enable high;
//    req[0] drops mid-DRAIN -> ack still issued after fb low.
//  6 Assert reset_n low during GATE -> div_enable=run, div_ratio=2, busy=0 immediately.
//    With CLKDIV_CFG_TIMEOUT_EN and TIMEOUT=8, fb stuck high -> timeout pulse at DRAIN cycle 8, then ack.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: FSM state encoding and ratio-validity helper shared by the divider scheduler and the divider
package clkdiv_pkg;
   typedef logic [2:0] state_t;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DRAIN  = 3'd1;
   localparam logic [2:0] ST_GATE   = 3'd2;
   localparam logic [2:0] ST_LOAD   = 3'd3;
   localparam logic [2:0] ST_RESUME = 3'd4;
   function automatic logic ratio_ok(input logic [31:0] r);
      return r >= 32'd2;
   endfunction
endpackage

// File: rtl/clkdiv_cfg_sched_if.sv
// clkdiv_cfg_sched_if: requester-side bundle, per-requester ratio requests in, one-hot ack and err out
interface clkdiv_cfg_sched_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
);
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] req_ratio;
   logic [NREQ-1:0]       ack;
   logic                  err;
   modport master (output req, req_ratio, input ack, err);
   modport slave  (input req, req_ratio, output ack, err);
endinterface

// File: rtl/clkdiv_rr_arb.sv
// clkdiv_rr_arb: combinational round-robin arbiter, first set request at or after the pointer wins
module clkdiv_rr_arb #(
   parameter int NREQ = 4,
   localparam int IW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            vld_o
);
   logic hit;
   // scan requesters starting at the pointer, wrapping, and keep the first hit
   always_comb begin
      hit   = 1'b0;
      gnt_o = '0;
      idx_o = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!hit && req_i[(int'(ptr_i) + i) % NREQ]) begin
            hit = 1'b1;
            idx_o = IW'((int'(ptr_i) + i) % NREQ);
            gnt_o[(int'(ptr_i) + i) % NREQ] = 1'b1;
         end
      end
      vld_o = hit;
   end
endmodule

// File: rtl/clkdiv_cfg_sched.sv
// clkdiv_cfg_sched: arbitrates divider ratio changes and sequences drain/gate/load/resume (optional CLKDIV_CFG_TIMEOUT_EN adds a DRAIN timeout)
module clkdiv_cfg_sched
   import clkdiv_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int NREQ        = 4,
   parameter int STALL       = 2,
   parameter int RESET_RATIO = 2,
   parameter int TIMEOUT     = 255
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               run,
   input  logic               div_clk_fb,
   clkdiv_cfg_sched_if.slave  cfg,
   output logic               div_enable,
   output logic [WIDTH-1:0]   div_ratio,
   output logic               busy
`ifdef CLKDIV_CFG_TIMEOUT_EN
   ,
   output logic               timeout
`endif
);
   localparam int IW   = $clog2(NREQ);
   localparam int CMAX = (STALL > TIMEOUT) ? STALL : TIMEOUT;
   localparam int CW   = $clog2(CMAX + 1);

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d, idx_q, idx_d;
   logic [WIDTH-1:0] lat_q, lat_d, ratio_q, ratio_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             err_q, err_d, en_q, en_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [NREQ-1:0]  ggnt;
   logic [IW-1:0]    gidx;
   logic             gvld, to;
   logic [WIDTH-1:0] gratio;

   clkdiv_rr_arb #(.NREQ(NREQ)) u_arb (
      .req_i (cfg.req),
      .ptr_i (ptr_q),
      .gnt_o (ggnt),
      .idx_o (gidx),
      .vld_o (gvld)
   );

   assign gratio = cfg.req_ratio[int'(gidx)*WIDTH +: WIDTH];

`ifdef CLKDIV_CFG_TIMEOUT_EN
   assign to      = (state_q == ST_DRAIN) && div_clk_fb && (cnt_q == CW'(TIMEOUT - 1));
   assign timeout = to;
`else
   assign to = 1'b0;
`endif

   // next-state logic: grant in IDLE, then walk the change sequence and schedule the ack pulse
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      lat_d   = lat_q;
      ratio_d = ratio_q;
      cnt_d   = cnt_q;
      ack_d   = '0;
      err_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gvld) begin
               ptr_d = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
               idx_d = gidx;
               lat_d = gratio;
               cnt_d = '0;
               if (!ratio_ok(32'(gratio))) begin
                  ack_d = ggnt;
                  err_d = 1'b1;
               end else if (gratio == ratio_q) begin
                  ack_d = ggnt;
               end else begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
`ifdef CLKDIV_CFG_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (!div_clk_fb || to) begin
               state_d = ST_GATE;
               cnt_d   = '0;
            end
         end
         ST_GATE: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == CW'(STALL - 1)) ? ST_LOAD : ST_GATE;
         end
         ST_LOAD: begin
            ratio_d = lat_q;
            ack_d   = NREQ'(1) << idx_q;
            state_d = ST_RESUME;
         end
         default: state_d = ST_IDLE;
      endcase
      en_d = !((state_d == ST_GATE) || (state_d == ST_LOAD));
   end

   // state and datapath registers, asynchronously returned to the reset values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         lat_q   <= '0;
         ratio_q <= WIDTH'(RESET_RATIO);
         cnt_q   <= '0;
         ack_q   <= '0;
         err_q   <= 1'b0;
         en_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         lat_q   <= lat_d;
         ratio_q <= ratio_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         en_q    <= en_d;
      end
   end

   assign cfg.ack    = ack_q;
   assign cfg.err    = err_q;
   assign div_enable = run & en_q;
   assign div_ratio  = ratio_q;
   assign busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_clkdiv_cfg_sched.sv
// tb_clkdiv_cfg_sched: scoreboard bench with a transaction-level round-robin/ratio model
module tb_clkdiv_cfg_sched;
   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int STALL = 2;

   typedef struct {
      int idx;
      int err;
      int ratio;
      int low;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             run = 1'b1;
   logic             div_clk_fb = 1'b0;
   logic             div_enable, busy;
   logic [WIDTH-1:0] div_ratio;
`ifdef CLKDIV_CFG_TIMEOUT_EN
   logic             timeout;
`endif

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   lowc = 0;
   int   m_ptr = 0;
   int   m_cur = 2;
   int   rat[NREQ];

   clkdiv_cfg_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) cfg ();

   clkdiv_cfg_sched #(
      .WIDTH(WIDTH), .NREQ(NREQ), .STALL(STALL), .RESET_RATIO(2), .TIMEOUT(255)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .run        (run),
      .div_clk_fb (div_clk_fb),
      .cfg        (cfg),
      .div_enable (div_enable),
      .div_ratio  (div_ratio),
      .busy       (busy)
`ifdef CLKDIV_CFG_TIMEOUT_EN
      ,
      .timeout    (timeout)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   // reference: grant order by round-robin from the model pointer, rejects for ratio<2, no gating if unchanged
   task automatic model_round(input logic [NREQ-1:0] mask);
      logic [NREQ-1:0] pend;
      exp_t e;
      int w;
      pend = mask;
      while (pend != 0) begin
         w = -1;
         for (int k = 0; k < NREQ; k++)
            if (w < 0 && pend[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
         pend[w] = 1'b0;
         m_ptr = (w + 1) % NREQ;
         e.idx = w;
         e.err = (rat[w] < 2) ? 1 : 0;
         e.low = (rat[w] >= 2 && rat[w] != m_cur) ? STALL + 1 : 0;
         if (rat[w] >= 2) m_cur = rat[w];
         e.ratio = m_cur;
         exp_q.push_back(e);
      end
   endtask

   task automatic issue(input logic [NREQ-1:0] mask);
      model_round(mask);
      for (int i = 0; i < NREQ; i++) cfg.req_ratio[i*WIDTH +: WIDTH] = WIDTH'(rat[i]);
      cfg.req = mask;
   endtask

   task automatic drain(input int budget, input bit rnd_fb);
      int n;
      for (n = 0; n < budget; n++) begin
         @(negedge clk);
         cfg.req = cfg.req & ~cfg.ack;
         if (rnd_fb) div_clk_fb = 1'($urandom);
         if (cfg.req == 0 && !busy) break;
      end
      if (n >= budget) begin
         compared++;
         mismatched++;
         $display("FAIL drain_budget: req=%b busy=%b still pending after %0d cycles", cfg.req, busy, budget);
      end
      repeat (2) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
   endtask

   // monitor: pop expectation on every ack/err, count gated cycles in between
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         lowc = 0;
      end else if (cfg.ack != 0 || cfg.err) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_ack: ack=%b err=%b with nothing outstanding", cfg.ack, cfg.err);
         end else begin
            e = exp_q.pop_front();
            chk("ack_onehot", int'(cfg.ack), 1 << e.idx);
            chk("err", int'(cfg.err), e.err);
            chk("div_ratio", int'(div_ratio), e.ratio);
            chk("gate_cycles", lowc, e.low);
            chk("enable_at_ack", int'(div_enable), 1);
         end
         lowc = 0;
      end else if (run && !div_enable) begin
         lowc++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int prev;
      cfg.req = '0;
      cfg.req_ratio = '0;
      for (int i = 0; i < NREQ; i++) rat[i] = 0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_ratio", int'(div_ratio), 2);
      chk("rst_enable", int'(div_enable), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ack", int'(cfg.ack), 0);
      chk("rst_err", int'(cfg.err), 0);
      run = 1'b0;
      #1 chk("run_off", int'(div_enable), 0);
      run = 1'b1;
      @(negedge clk);
      div_clk_fb = 1'b0;
      rat[1] = 5;
      issue(4'b0010);
      for (n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (cfg.ack != 0) break;
      end
      cfg.req = cfg.req & ~cfg.ack;
      chk("latency", n, 3 + STALL);
      drain(50, 1'b0);
      rat[0] = 0;
      issue(4'b0001);
      drain(50, 1'b0);
      rat[0] = 7; rat[2] = 6; rat[3] = 3;
      issue(4'b1101);
      drain(100, 1'b0);
      rat[2] = 1;
      prev = m_cur;
      issue(4'b0100);
      drain(50, 1'b0);
      chk("reject_keeps_ratio", int'(div_ratio), prev);
      div_clk_fb = 1'b1;
      prev = m_cur;
      rat[0] = (m_cur == 4) ? 6 : 4;
      issue(4'b0001);
      repeat (10) @(negedge clk);
      chk("drain_busy", int'(busy), 1);
      chk("drain_enable", int'(div_enable), 1);
      chk("drain_ratio", int'(div_ratio), prev);
      cfg.req = '0;
      repeat (3) @(negedge clk);
      chk("drain_hold", int'(busy), 1);
      div_clk_fb = 1'b0;
      drain(50, 1'b0);
      rat[3] = (m_cur == 9) ? 10 : 9;
      issue(4'b1000);
      repeat (2) @(negedge clk);
      chk("gate_low", int'(div_enable), 0);
      #1 reset_n = 1'b0;
      #1;
      chk("mid_rst_enable", int'(div_enable), 1);
      chk("mid_rst_ratio", int'(div_ratio), 2);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_ack", int'(cfg.ack), 0);
      exp_q.delete();
      cfg.req = '0;
      m_ptr = 0;
      m_cur = 2;
      @(negedge clk);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", int'(busy), 0);
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < NREQ; i++) rat[i] = $urandom_range(0, 7);
         issue(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
         drain(400, 1'b1);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
